// File: rtl/bram_stream_reader.sv
// Reads WORD_COUNT words from the communication BRAM and streams them out as
// halfwords (upper half first) on a valid/ready interface toward the learning datapath.
module bram_stream_reader #(
    parameter logic [31:0] BASE_ADDR  = 32'hB000_0000,
    parameter int unsigned WORD_COUNT = 68
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] bram_address,
    output logic        bram_enable,
    input  logic [31:0] bram_data,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_FINISH = 2'd2;

    localparam logic [16:0] WC       = 17'(WORD_COUNT);
    localparam logic [16:0] LAST_IDX = WC - 17'd1;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [16:0] issue_cnt;
    logic [16:0] head_idx;
    logic        rd_pending;
    logic [31:0] buf0;
    logic [31:0] buf1;
    logic [1:0]  occ;
    logic        sel;
    logic        hs;
    logic        pop;
    logic        push;
    logic        last_hs;
    logic        can_issue;
    logic [2:0]  demand;

    assign out_valid = (occ != 2'd0);
    assign out_data  = !out_valid ? '0 : (sel ? buf0[15:0] : buf0[31:16]);
    assign out_last  = out_valid && sel && (head_idx == LAST_IDX);
    assign hs        = out_valid && out_ready;
    assign pop       = hs && sel;
    assign push      = rd_pending && (state == ST_RUN);
    assign last_hs   = pop && (head_idx == LAST_IDX);

    // Buffered words plus reads still in flight, with a same-cycle pop counted as freed.
    always_comb begin
        demand    = {1'b0, occ} + {2'b00, bram_enable} + {2'b00, rd_pending} + 3'd1 - {2'b00, pop};
        can_issue = (state == ST_RUN) && (issue_cnt < WC) && (demand <= 3'd2);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = (WC == 17'd0) ? ST_FINISH : ST_RUN;
            ST_RUN:    if (last_hs) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            bram_enable  <= 1'b0;
            bram_address <= BASE_ADDR;
            rd_pending   <= 1'b0;
            issue_cnt    <= '0;
            head_idx     <= '0;
            sel          <= 1'b0;
            occ          <= '0;
            buf0         <= '0;
            buf1         <= '0;
        end else begin
            state      <= state_nxt;
            done       <= (state == ST_FINISH);
            busy       <= (state_nxt != ST_IDLE) || (state == ST_FINISH);
            rd_pending <= bram_enable;

            if ((state == ST_IDLE) && start && (WC != 17'd0)) begin
                bram_enable  <= 1'b1;
                bram_address <= BASE_ADDR;
                issue_cnt    <= 17'd1;
                head_idx     <= '0;
                sel          <= 1'b0;
            end else if (can_issue) begin
                bram_enable  <= 1'b1;
                bram_address <= BASE_ADDR + {13'b0, issue_cnt, 2'b00};
                issue_cnt    <= issue_cnt + 17'd1;
            end else begin
                bram_enable  <= 1'b0;
            end

            if (hs) sel <= !sel;
            if (pop) head_idx <= head_idx + 17'd1;

            // buf0 is always the head; a pop shifts buf1 forward.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) buf0 <= bram_data;
                    else             buf1 <= bram_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    buf0 <= buf1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        buf0 <= bram_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= bram_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
